// File: rtl/checker_pkg.sv
// Shared types for the register check engine: scan FSM states and the
// expected-value table entry.
package checker_pkg;

    // Table entry widths; the engine's XLEN/REG_AW parameters must match these.
    localparam int CHK_XLEN   = 32;
    localparam int CHK_REG_AW = 5;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SCAN_REQ,
        SCAN_CMP,
        DONE
    } check_state_t;

    typedef struct packed {
        logic [CHK_REG_AW-1:0] reg_num;
        logic [CHK_XLEN-1:0]   val;
        logic [CHK_XLEN-1:0]   mask;
        logic                  valid;
    } check_entry_t;

    function automatic logic masked_eq(input logic [CHK_XLEN-1:0] got,
                                       input logic [CHK_XLEN-1:0] exp,
                                       input logic [CHK_XLEN-1:0] mask);
        return ((got ^ exp) & mask) == '0;
    endfunction

endpackage

// File: rtl/reg_check_engine_quiet_detector.sv
// Run-phase activity monitor: counts consecutive idle write-back cycles and
// total run cycles, flagging quiescence or timeout on the cycle they are reached.
module quiet_detector #(
    parameter int QUIET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic wb_en,
    output logic quiet_hit,
    output logic timeout_hit
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [QW-1:0] quiet_q;
    logic [TW-1:0] run_q;

    // Hits fire on the cycle whose count update would reach the threshold,
    // so the FSM leaves RUN on exactly that edge.
    assign quiet_hit   = run && !wb_en && (quiet_q == QW'(QUIET_CYCLES - 1));
    assign timeout_hit = run && (run_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            quiet_q <= '0;
            run_q   <= '0;
        end else if (run) begin
            quiet_q <= wb_en ? '0 : quiet_q + 1'b1;
            run_q   <= run_q + 1'b1;
        end
    end

endmodule

// File: rtl/reg_check_engine.sv
// Watches cpu write-back until quiet or timeout, then scans the expected-value
// table through a register-file read port and reports pass/fail results.
module reg_check_engine #(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int NUM_CHECKS     = 8,
    parameter int QUIET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             exp_wr_en,
    input  logic [$clog2(NUM_CHECKS)-1:0]    exp_idx,
    input  logic [REG_AW-1:0]                exp_reg,
    input  logic [XLEN-1:0]                  exp_val,
    input  logic [XLEN-1:0]                  exp_mask,
    input  logic                             exp_valid,
    input  logic                             start,
    input  logic                             wb_en,
    input  logic [REG_AW-1:0]                wb_rd,
    output logic [REG_AW-1:0]                rf_raddr,
    input  logic [XLEN-1:0]                  rf_rdata,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0]  pass_cnt,
    output logic [$clog2(NUM_CHECKS+1)-1:0]  fail_cnt,
    output logic [$clog2(NUM_CHECKS)-1:0]    first_fail_idx,
    output logic [XLEN-1:0]                  first_fail_got,
    output logic                             any_fail
);
    import checker_pkg::*;

    localparam int IW = $clog2(NUM_CHECKS);
    localparam int CW = $clog2(NUM_CHECKS + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_CHECKS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_CHECKS);

    check_entry_t  tbl [NUM_CHECKS];
    check_entry_t  cur;
    check_state_t  state;
    logic [IW-1:0] ptr;
    logic [REG_AW-1:0] raddr_q;
    logic idle_or_done, launch, match, quiet_hit, timeout_hit;
    logic unused_wb_rd;

    assign cur          = tbl[ptr];
    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign launch       = start && idle_or_done;
    assign match        = masked_eq(rf_rdata, cur.val, cur.mask);
    assign unused_wb_rd = ^wb_rd;

    // The address is presented during SCAN_REQ so a synchronous-read register
    // file returns data in SCAN_CMP; it is then held for the compare cycle.
    assign rf_raddr = (state == SCAN_REQ && cur.valid) ? cur.reg_num : raddr_q;

    quiet_detector #(
        .QUIET_CYCLES   (QUIET_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_quiet (
        .clk         (clk),
        .reset       (reset),
        .clear       (launch),
        .run         (state == RUN),
        .wb_en       (wb_en),
        .quiet_hit   (quiet_hit),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) tbl[i].valid <= 1'b0;
        end else if (exp_wr_en && idle_or_done && (32'(exp_idx) < NUM_CHECKS)) begin
            tbl[exp_idx] <= '{reg_num: exp_reg, val: exp_val, mask: exp_mask, valid: exp_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            raddr_q        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            any_fail       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        timeout        <= 1'b0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        first_fail_got <= '0;
                        any_fail       <= 1'b0;
                    end
                end
                RUN: begin
                    // Quiescence takes priority when both thresholds land together.
                    if (quiet_hit || timeout_hit) begin
                        state   <= SCAN_REQ;
                        ptr     <= '0;
                        timeout <= !quiet_hit;
                    end
                end
                SCAN_REQ: begin
                    if (cur.valid) begin
                        raddr_q <= cur.reg_num;
                        state   <= SCAN_CMP;
                    end else if (ptr == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                SCAN_CMP: begin
                    if (match) begin
                        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                        if (!any_fail) begin
                            first_fail_idx <= ptr;
                            first_fail_got <= rf_rdata;
                        end
                        any_fail <= 1'b1;
                    end
                    if (ptr == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ptr   <= ptr + 1'b1;
                        state <= SCAN_REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
